uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKs_per_bit, default 100, clock cycles per serial bit, legal range >= 2.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame, legal values 1 or 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO entries, power of 2, >= 2.
REQ-006 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port start_sending  input  1  push strobe; enqueues data_in when sampled high.
REQ-009 SHALL have port data_in  input  DATA_BITS  word to enqueue.
REQ-010 SHALL have port data_out  output  1  serial line, idle high.
REQ-011 SHALL have port busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-012 SHALL have port full  output  1  high when the FIFO holds FIFO_DEPTH entries.
REQ-013 SHALL have port level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-014 SHALL have port done  output  1  one-cycle pulse at end of each frame.

Function
REQ-015 SHALL accept a push when start_sending=1 and full=0; the push is silently dropped when full=1, with no state change.
REQ-016 SHALL evaluate full from the registered occupancy, so a pop in the same cycle does not permit a push into a full FIFO.
REQ-017 SHALL update level by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-018 SHALL be FIFO-ordered, with read and write pointers wrapping modulo FIFO_DEPTH.
REQ-019 SHALL implement the FSM IDLE, START, DATA, PAR, STOP.
REQ-020 SHALL, in IDLE with level>0, pop the head word into the shift register and enter START at that edge; with level=0 it SHALL stay in IDLE with data_out=1.
REQ-021 SHALL drive data_out low (start bit) from the pop edge, i.e. one cycle after the push edge when the FIFO was empty and the FSM was IDLE.
REQ-022 SHALL hold every bit for exactly CLKs_per_bit cycles, timed by a bit counter that wraps from CLKs_per_bit-1 to 0.
REQ-023 SHALL, in DATA, send DATA_BITS bits LSB first, then go to PAR when PARITY!=0, else to STOP.
REQ-024 SHALL, in PAR, send XOR of the data bits for even parity and its inverse for odd parity.
REQ-025 SHALL, in STOP, drive data_out high for STOP_BITS*CLKs_per_bit cycles.
REQ-026 SHALL have a frame length of (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKs_per_bit cycles.
REQ-027 SHALL assert done for exactly the last cycle of the final stop bit.
REQ-028 SHALL, at the edge ending STOP, pop and enter START directly when level>0, giving back-to-back frames with no idle cycle; otherwise it SHALL enter IDLE.
REQ-029 SHALL assert busy when state!=IDLE or level>0.
REQ-030 SHALL register data_out so it is glitch-free.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, force state=IDLE, data_out=1, busy=0, full=0, level=0, done=0, and clear the pointers and counters.
REQ-032 SHALL, when reset occurs mid-frame, abort the frame immediately, emit no done pulse, and discard all FIFO contents.
REQ-033 SHALL give rst priority over a simultaneous start_sending, so the push is dropped.

Verification
REQ-034 SHALL pass 8N1 (CLKs_per_bit=4): push 0xA6 into the idle block -> line 0,0,1,1,0,0,1,0,1,1, each bit 4 cycles; done pulses 40 cycles after the start bit begins; busy then falls.
REQ-035 SHALL pass 8E1 and 8O1: push 0x07 -> parity bit is 1 (even) and 0 (odd); frame is 44 cycles.
REQ-036 SHALL pass FIFO fill (FIFO_DEPTH=4): push 6 words on consecutive cycles -> first word is popped at once, next 4 are queued with full=1 and level=4, the 6th is dropped, and exactly 5 frames are transmitted in order.
REQ-037 SHALL pass back-to-back: two pushes -> the start bit of frame 2 begins on the cycle after done of frame 1.
REQ-038 SHALL pass mid-frame reset: assert rst during a DATA bit with level=2 -> next cycle data_out=1, level=0, busy=0; no done pulse; no further frames.
REQ-039 SHALL pass 5N2 (DATA_BITS=5, STOP_BITS=2): push 0x15 -> line 0,1,0,1,0,1,1,1; frame is 8*CLKs_per_bit cycles.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO in front of it.
// Words pushed on start_sending are queued and sent as
// start / data (LSB first) / optional parity / stop frames.
// Queued words go out back to back, with no idle cycle between frames.
module uart_tx_fifo #(
   parameter int CLKs_per_bit = 100,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,   // 0 none, 1 odd, 2 even
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start_sending,
   input  logic [DATA_BITS-1:0]          data_in,
   output logic                          data_out,
   output logic                          busy,
   output logic                          full,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          done
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(CLKs_per_bit);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

   state_t               r_state, w_state_nx;
   logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]        r_wptr, r_rptr;
   logic [LW-1:0]        r_level;
   logic [CW-1:0]        r_cnt, w_cnt_nx;
   logic [3:0]           r_bit, w_bit_nx;
   logic [DATA_BITS-1:0] r_shift, w_shift_nx;
   logic                 r_par;
   logic                 r_txd, w_txd_nx;
   logic                 w_push, w_pop, w_tick, w_done, w_full, w_par_head;
   logic [DATA_BITS-1:0] w_head;

   // Full comes from the registered occupancy, so a pop in the same
   // cycle never makes room for a push into a full FIFO.
   assign w_full     = (r_level == LW'(FIFO_DEPTH));
   assign w_push     = start_sending & ~w_full;
   assign w_tick     = (r_cnt == CW'(CLKs_per_bit - 1));
   assign w_head     = r_mem[r_rptr];
   assign w_par_head = (PARITY == 1) ? ~(^w_head) : (^w_head);

   assign data_out = r_txd;
   assign busy     = (r_state != S_IDLE) || (r_level != '0);
   assign full     = w_full;
   assign level    = r_level;
   assign done     = w_done;

   // Next-state, next line value and pop decision for the frame sequencer.
   always_comb begin
      w_state_nx = r_state;
      w_pop      = 1'b0;
      w_done     = 1'b0;
      w_txd_nx   = r_txd;
      w_bit_nx   = r_bit;
      w_shift_nx = r_shift;
      w_cnt_nx   = w_tick ? '0 : r_cnt + 1'b1;
      case (r_state)
         S_IDLE: begin
            w_cnt_nx = '0;
            w_txd_nx = 1'b1;
            if (r_level != '0) begin
               w_pop      = 1'b1;
               w_state_nx = S_START;
               w_txd_nx   = 1'b0;
               w_shift_nx = w_head;
            end
         end
         S_START: begin
            if (w_tick) begin
               w_state_nx = S_DATA;
               w_txd_nx   = r_shift[0];
               w_bit_nx   = '0;
            end
         end
         S_DATA: begin
            if (w_tick) begin
               if (r_bit == 4'(DATA_BITS - 1)) begin
                  w_bit_nx = '0;
                  if (PARITY != 0) begin
                     w_state_nx = S_PAR;
                     w_txd_nx   = r_par;
                  end else begin
                     w_state_nx = S_STOP;
                     w_txd_nx   = 1'b1;
                  end
               end else begin
                  w_bit_nx   = r_bit + 4'd1;
                  w_shift_nx = r_shift >> 1;
                  w_txd_nx   = r_shift[1];
               end
            end
         end
         S_PAR: begin
            if (w_tick) begin
               w_state_nx = S_STOP;
               w_txd_nx   = 1'b1;
               w_bit_nx   = '0;
            end
         end
         S_STOP: begin
            w_txd_nx = 1'b1;
            if (w_tick) begin
               if (r_bit == 4'(STOP_BITS - 1)) begin
                  // Last cycle of the final stop bit: flag it and either
                  // chain straight into the next queued frame or go idle.
                  w_done = 1'b1;
                  if (r_level != '0) begin
                     w_pop      = 1'b1;
                     w_state_nx = S_START;
                     w_txd_nx   = 1'b0;
                     w_shift_nx = w_head;
                  end else begin
                     w_state_nx = S_IDLE;
                  end
               end else begin
                  w_bit_nx = r_bit + 4'd1;
               end
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // Sequencer, FIFO pointers/occupancy and registered serial line.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_txd   <= 1'b1;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_bit   <= w_bit_nx;
         r_shift <= w_shift_nx;
         r_txd   <= w_txd_nx;
         if (w_pop) begin
            r_par  <= w_par_head;
            r_rptr <= r_rptr + 1'b1;
         end
         if (w_push) r_wptr <= r_wptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   // FIFO storage; contents need no reset because occupancy gates reads.
   always_ff @(posedge clk) begin
      if (!rst && w_push) r_mem[r_wptr] <= data_in;
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances (8N1, 8E1, 8O1, 5N2) share one clock.
// The line is predicted from frame rules; bursts use a queue-level model.
module tb_uart_tx_fifo;

   localparam int N     = 4;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int DB [N] = '{8, 8, 8, 5};
   localparam int PAR[N] = '{0, 2, 1, 0};
   localparam int SB [N] = '{1, 1, 1, 2};

   logic       clk = 1'b0;
   logic       rst  [N];
   logic       st   [N];
   logic [8:0] din  [N];
   logic       dout [N];
   logic       busy [N];
   logic       full [N];
   logic       done [N];
   logic [2:0] lvl  [N];

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      uart_tx_fifo #(
         .CLKs_per_bit(CPB), .DATA_BITS(DB[g]), .PARITY(PAR[g]),
         .STOP_BITS(SB[g]), .FIFO_DEPTH(DEPTH)
      ) u_dut (
         .clk(clk), .rst(rst[g]), .start_sending(st[g]),
         .data_in(din[g][DB[g]-1:0]), .data_out(dout[g]), .busy(busy[g]),
         .full(full[g]), .level(lvl[g]), .done(done[g])
      );
   end

   function automatic int frame_len(int i);
      return (1 + DB[i] + ((PAR[i] != 0) ? 1 : 0) + SB[i]) * CPB;
   endfunction

   // Expected line value k cycles into the frame carrying word d.
   function automatic logic exp_bit(int i, logic [8:0] d, int k);
      int b;
      logic [8:0] m;
      m = d & ((9'h1 << DB[i]) - 9'h1);
      b = k / CPB;
      if (b == 0) return 1'b0;
      b = b - 1;
      if (b < DB[i]) return m[b];
      b = b - DB[i];
      if (PAR[i] != 0 && b == 0) return (PAR[i] == 2) ? ^m : ~(^m);
      return 1'b1;
   endfunction

   task automatic test_reset();
      for (int i = 0; i < N; i++) begin rst[i] = 1'b1; st[i] = 1'b1; din[i] = 9'h0AA; end
      repeat (2) @(negedge clk);
      for (int i = 0; i < N; i++) begin
         n_chk++;
         if ({dout[i], busy[i], full[i], lvl[i], done[i]} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset idx=%0d got=%b exp=%b", i,
                     {dout[i], busy[i], full[i], lvl[i], done[i]}, 7'b1000000);
         end
      end
      for (int i = 0; i < N; i++) begin rst[i] = 1'b0; st[i] = 1'b0; end
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         n_chk++;
         if (lvl[i] !== 3'd0 || busy[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_push_drop idx=%0d level=%0d busy=%b exp level=0 busy=0",
                     i, lvl[i], busy[i]);
         end
      end
   endtask

   // Single word into an idle block; plen!=0 selects a fixed bit pattern.
   task automatic test_frame(int i, logic [8:0] d, int plen, logic [11:0] pat);
      int   fl;
      logic e;
      fl = frame_len(i);
      @(negedge clk); st[i] = 1'b1; din[i] = d;
      @(negedge clk); st[i] = 1'b0;
      n_chk++;
      if ({dout[i], lvl[i], busy[i]} !== {1'b1, 3'd1, 1'b1}) begin
         n_fail++;
         $display("FAIL frame_queued idx=%0d got line/level/busy=%b/%0d/%b exp 1/1/1",
                  i, dout[i], lvl[i], busy[i]);
      end
      for (int k = 0; k < fl; k++) begin
         @(negedge clk);
         e = (plen != 0) ? pat[k / CPB] : exp_bit(i, d, k);
         n_chk++;
         if (dout[i] !== e) begin
            n_fail++;
            $display("FAIL frame_line idx=%0d data=%h k=%0d got=%b exp=%b", i, d, k, dout[i], e);
         end
         n_chk++;
         if (done[i] !== (k == fl - 1)) begin
            n_fail++;
            $display("FAIL frame_done idx=%0d k=%0d got=%b exp=%b", i, k, done[i], (k == fl - 1));
         end
      end
      @(negedge clk);
      n_chk++;
      if ({dout[i], busy[i], done[i], lvl[i]} !== 6'b100000) begin
         n_fail++;
         $display("FAIL frame_idle idx=%0d got=%b exp=%b", i,
                  {dout[i], busy[i], done[i], lvl[i]}, 6'b100000);
      end
   endtask

   // np pushes on consecutive cycles; late=1 adds a push at the cycle a
   // pop frees a slot of the full FIFO, which must still be dropped.
   task automatic test_burst(int i, int np, bit late);
      logic [8:0] wd [8];
      int fl, acc, total, j, f, ob, el;
      logic e, ed;
      fl    = frame_len(i);
      acc   = (np > DEPTH + 1) ? DEPTH + 1 : np;
      total = 2 + acc * fl + 2;
      for (int k = 0; k < 8; k++) wd[k] = 9'($urandom);
      for (int n = 0; n < total; n++) begin
         @(negedge clk);
         if (n >= 2) begin
            j  = n - 2;
            f  = j / fl;
            ob = j % fl;
            e  = (f < acc) ? exp_bit(i, wd[f], ob) : 1'b1;
            ed = (f < acc) && (ob == fl - 1);
            n_chk++;
            if (dout[i] !== e) begin
               n_fail++;
               $display("FAIL burst_line idx=%0d frame=%0d k=%0d got=%b exp=%b", i, f, ob, dout[i], e);
            end
            n_chk++;
            if (done[i] !== ed) begin
               n_fail++;
               $display("FAIL burst_done idx=%0d frame=%0d k=%0d got=%b exp=%b", i, f, ob, done[i], ed);
            end
            if (f >= 1 && f < acc && ob == 0) begin
               n_chk++;
               if (lvl[i] !== 3'(acc - 1 - f)) begin
                  n_fail++;
                  $display("FAIL burst_level_pop idx=%0d frame=%0d got=%0d exp=%0d", i, f, lvl[i], acc - 1 - f);
               end
            end
         end
         if (n == np && np >= 2) begin
            el = (np - 1 > DEPTH) ? DEPTH : np - 1;
            n_chk++;
            if (lvl[i] !== 3'(el) || full[i] !== (el == DEPTH)) begin
               n_fail++;
               $display("FAIL burst_fill idx=%0d level=%0d full=%b exp level=%0d full=%b",
                        i, lvl[i], full[i], el, (el == DEPTH));
            end
         end
         st[i]  = (n < np) || (late && n == fl + 1);
         din[i] = (n < np) ? wd[n] : 9'($urandom);
      end
      st[i] = 1'b0;
      n_chk++;
      if (busy[i] !== 1'b0 || lvl[i] !== 3'd0) begin
         n_fail++;
         $display("FAIL burst_end idx=%0d busy=%b level=%0d exp busy=0 level=0", i, busy[i], lvl[i]);
      end
   endtask

   // Reset while a data bit is on the line and two words wait behind it.
   task automatic test_mid_reset();
      int fl;
      fl = frame_len(0);
      for (int n = 0; n < 2 * CPB + 4; n++) begin
         @(negedge clk);
         if (n == 2 * CPB + 3) begin
            n_chk++;
            if (lvl[0] !== 3'd2) begin
               n_fail++;
               $display("FAIL midrst_pre level got=%0d exp=2", lvl[0]);
            end
            rst[0] = 1'b1;
            st[0]  = 1'b1;
         end else begin
            st[0]  = (n < 3);
            din[0] = 9'($urandom);
         end
      end
      @(negedge clk);
      rst[0] = 1'b0;
      st[0]  = 1'b0;
      n_chk++;
      if ({dout[0], lvl[0], busy[0], full[0], done[0]} !== 7'b1000000) begin
         n_fail++;
         $display("FAIL midrst_after got=%b exp=%b",
                  {dout[0], lvl[0], busy[0], full[0], done[0]}, 7'b1000000);
      end
      for (int k = 0; k < 3 * fl; k++) begin
         @(negedge clk);
         n_chk++;
         if (dout[0] !== 1'b1 || done[0] !== 1'b0 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_quiet k=%0d line=%b done=%b busy=%b exp 1/0/0",
                     k, dout[0], done[0], busy[0]);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin rst[i] = 1'b1; st[i] = 1'b0; din[i] = '0; end
      test_reset();
      test_frame(0, 9'h0A6, 10, 12'h34C);
      test_frame(1, 9'h007, 11, 12'h60E);
      test_frame(2, 9'h007, 11, 12'h40E);
      test_frame(3, 9'h015, 8, 12'h0EA);
      for (int i = 0; i < N; i++)
         for (int r = 0; r < 3; r++) test_frame(i, 9'($urandom), 0, 12'h0);
      test_burst(0, 6, 1'b1);
      test_burst(3, 2, 1'b0);
      test_burst(1, 3, 1'b0);
      test_burst(2, 7, 1'b1);
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
